// File: rtl/trace_pkg.sv
// Shared definitions for the trace sequencer: step layout, register
// indices and the sequencer state encoding.
package trace_pkg;

    localparam int STEP_W = 560;
    localparam int NREGS  = 10;
    localparam int REG_W  = 32;
    localparam int REGS_W = NREGS * REG_W;

    // Step field offsets (inclusive bit positions)
    localparam int INSTR_HI = 559;
    localparam int INSTR_LO = 464;
    localparam int REGS_HI  = 463;
    localparam int REGS_LO  = 144;
    localparam int HINT1_HI = 143;
    localparam int HINT1_LO = 72;
    localparam int HINT2_HI = 71;
    localparam int HINT2_LO = 0;

    // Register indices; also the bit order of CHECK_MASK and fail_mask
    localparam int REG_EAX    = 0;
    localparam int REG_EBX    = 1;
    localparam int REG_ECX    = 2;
    localparam int REG_EDX    = 3;
    localparam int REG_ESI    = 4;
    localparam int REG_EDI    = 5;
    localparam int REG_ESP    = 6;
    localparam int REG_EBP    = 7;
    localparam int REG_EIP    = 8;
    localparam int REG_EFLAGS = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        EXEC  = 3'd2,
        CHECK = 3'd3,
        END   = 3'd4
    } state_t;

endpackage

// File: rtl/regs_compare.sv
// Per-register compare of the captured core result against the register
// field of the next trace step. The two vectors use opposite orders:
// the core result has eax in the low word, the step field has eax in the
// high word.
module regs_compare
    import trace_pkg::*;
(
    input  logic [REGS_W-1:0] exp_regs,
    input  logic [REGS_W-1:0] step_regs,
    input  logic [NREGS-1:0]  check_mask,
    output logic [NREGS-1:0]  mismatch
);

    // One mismatch bit per enabled register
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NREGS; i++) begin
            mismatch[i] = check_mask[i] &&
                (exp_regs[REG_W*i +: REG_W] != step_regs[REGS_W-1-REG_W*i -: REG_W]);
        end
    end

endmodule

// File: rtl/trace_sequencer.sv
// Feeds trace steps to a combinational single-step core and checks each
// computed register state against the registers of the following step.
//
// Handshake: a step moves from the source only in a cycle where
// step_valid && step_ready are both high at the rising clock edge;
// step_data and step_last are sampled in that cycle only, and step_last
// means nothing unless step_valid is also high.
module trace_sequencer
    import trace_pkg::*;
#(
    parameter int         STEP_W     = 560,
    parameter logic [9:0] CHECK_MASK = 10'h3FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step_valid,
    input  logic [STEP_W-1:0] step_data,
    input  logic              step_last,
    output logic              step_ready,
    output logic [STEP_W-1:0] dut_step,
    input  logic [REGS_W-1:0] dut_regs,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       fail_index,
    output logic [NREGS-1:0]  fail_mask,
    output logic [31:0]       steps_checked,
    output state_t            state_dbg
);

    state_t              state, next_state;
    logic [STEP_W-1:0]   prev, nxt_prev;
    logic [REGS_W-1:0]   exp_regs, nxt_exp;
    logic [31:0]         nxt_sc, nxt_fi;
    logic [NREGS-1:0]    nxt_fm, mismatch;
    logic                nxt_done, nxt_pass, nxt_busy, nxt_ready;
    logic                xfer;

    assign xfer      = step_valid && step_ready;
    assign dut_step  = prev;
    assign state_dbg = state;

    regs_compare u_cmp (
        .exp_regs   (exp_regs),
        .step_regs  (step_data[REGS_HI:REGS_LO]),
        .check_mask (CHECK_MASK),
        .mismatch   (mismatch)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; start is only honoured when no check is running
    always_comb begin
        next_state = state;
        case (state)
            IDLE, END: if (start) next_state = FIRST;
            FIRST:     if (xfer) next_state = step_last ? END : EXEC;
            EXEC:      next_state = CHECK;
            CHECK:     if (xfer) next_state = ((mismatch != '0) || step_last) ? END : EXEC;
            default:   next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        nxt_prev  = prev;
        nxt_exp   = exp_regs;
        nxt_sc    = steps_checked;
        nxt_fi    = fail_index;
        nxt_fm    = fail_mask;
        nxt_done  = done;
        nxt_pass  = pass;
        nxt_ready = (next_state == FIRST) || (next_state == CHECK);
        nxt_busy  = (next_state == FIRST) || (next_state == EXEC) || (next_state == CHECK);
        case (state)
            IDLE, END: begin
                if (start) begin
                    nxt_sc   = '0;
                    nxt_fi   = '0;
                    nxt_fm   = '0;
                    nxt_done = 1'b0;
                    nxt_pass = 1'b0;
                end
            end
            FIRST: begin
                if (xfer) begin
                    nxt_prev = step_data;
                    if (step_last) begin
                        nxt_done = 1'b1;
                        nxt_pass = 1'b1;
                    end
                end
            end
            EXEC: begin
                // The core has had one full cycle to settle on prev
                nxt_exp = dut_regs;
            end
            CHECK: begin
                if (xfer) begin
                    if (mismatch != '0) begin
                        // The diverging step is consumed but never executed
                        nxt_fm   = mismatch;
                        nxt_fi   = steps_checked;
                        nxt_done = 1'b1;
                        nxt_pass = 1'b0;
                    end else begin
                        nxt_prev = step_data;
                        nxt_sc   = (steps_checked == 32'hFFFF_FFFF) ? steps_checked
                                                                    : steps_checked + 32'd1;
                        if (step_last) begin
                            nxt_done = 1'b1;
                            nxt_pass = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev          <= '0;
            exp_regs      <= '0;
            steps_checked <= '0;
            fail_index    <= '0;
            fail_mask     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b0;
            step_ready    <= 1'b0;
        end else begin
            prev          <= nxt_prev;
            exp_regs      <= nxt_exp;
            steps_checked <= nxt_sc;
            fail_index    <= nxt_fi;
            fail_mask     <= nxt_fm;
            done          <= nxt_done;
            pass          <= nxt_pass;
            busy          <= nxt_busy;
            step_ready    <= nxt_ready;
        end
    end

endmodule

// File: tb/tb_trace_sequencer.sv
// Bench for trace_sequencer: two instances (full mask and 10'h0FF) share
// one step stream, each with its own model of the single-step core.
module tb_trace_sequencer;
    import trace_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         step_valid = 1'b0;
    logic         step_last = 1'b0;
    logic [559:0] step_data = '0;

    logic         rdy_a, busy_a, done_a, pass_a;
    logic [559:0] dstep_a;
    logic [319:0] dregs_a;
    logic [31:0]  fi_a, sc_a;
    logic [9:0]   fm_a;
    state_t       st_a;

    logic         rdy_b, busy_b, done_b, pass_b;
    logic [559:0] dstep_b;
    logic [319:0] dregs_b;
    logic [31:0]  fi_b, sc_b;
    logic [9:0]   fm_b;
    state_t       st_b;

    int total = 0;
    int bad = 0;

    logic [559:0] tr_q[$];
    logic [74:0]  exp_q_a[$];
    logic [74:0]  exp_q_b[$];
    logic [15:0]  rdy_hist;

    trace_sequencer #(.STEP_W(560), .CHECK_MASK(10'h3FF)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .step_valid(step_valid),
        .step_data(step_data), .step_last(step_last), .step_ready(rdy_a),
        .dut_step(dstep_a), .dut_regs(dregs_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_index(fi_a), .fail_mask(fm_a),
        .steps_checked(sc_a), .state_dbg(st_a)
    );

    trace_sequencer #(.STEP_W(560), .CHECK_MASK(10'h0FF)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .step_valid(step_valid),
        .step_data(step_data), .step_last(step_last), .step_ready(rdy_b),
        .dut_step(dstep_b), .dut_regs(dregs_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_index(fi_b), .fail_mask(fm_b),
        .steps_checked(sc_b), .state_dbg(st_b)
    );

    // Stand-in core: every register advances by the top instruction word plus its index
    function automatic logic [319:0] core_model(input logic [559:0] s);
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            r[32*i +: 32] = s[463-32*i -: 32] + s[559:528] + 32'(i);
        return r;
    endfunction

    always_comb dregs_a = core_model(dstep_a);
    always_comb dregs_b = core_model(dstep_b);

    function automatic logic [9:0] reg_diff(input logic [319:0] regs, input logic [559:0] s);
        logic [9:0] d;
        for (int i = 0; i < 10; i++)
            d[i] = (regs[32*i +: 32] != s[463-32*i -: 32]);
        return d;
    endfunction

    // Expected {pass, fail_index, fail_mask, steps_checked} for the trace in tr_q
    function automatic logic [74:0] expect_result(input logic [9:0] mask);
        logic       p;
        logic [31:0] fi, sc;
        logic [9:0] fm, mm;
        p = 1'b1; fi = '0; fm = '0; sc = 32'(tr_q.size() - 1);
        for (int k = 1; k < tr_q.size(); k++) begin
            mm = reg_diff(core_model(tr_q[k-1]), tr_q[k]) & mask;
            if (mm != '0) begin
                p = 1'b0; fi = 32'(k - 1); fm = mm; sc = 32'(k - 1);
                break;
            end
        end
        return {p, fi, fm, sc};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic build_trace(input int n, input int bad_step, input logic [9:0] bad_regs,
                               input logic [31:0] delta);
        logic [559:0] s;
        logic [319:0] r;
        tr_q.delete();
        for (int k = 0; k < n; k++) begin
            s = '0;
            for (int w = 0; w < 17; w++) s[32*w +: 32] = $urandom;
            s[559:544] = 16'($urandom_range(0, 65535));
            if (k > 0) begin
                r = core_model(tr_q[k-1]);
                for (int i = 0; i < 10; i++)
                    s[463-32*i -: 32] = r[32*i +: 32] +
                        (((bad_step < 0 || bad_step == k) && bad_regs[i]) ? delta : 32'd0);
            end
            tr_q.push_back(s);
        end
    endtask

    task automatic run_trace(input int n, input int bad_step, input logic [9:0] bad_regs,
                             input logic [31:0] delta, input bit gaps, input bit mid_start);
        logic [74:0] ea, eb;
        int idx, cyc, gap_left, w;
        bit acc;
        logic saw;
        build_trace(n, bad_step, bad_regs, delta);
        exp_q_a.push_back(expect_result(10'h3FF));
        exp_q_b.push_back(expect_result(10'h0FF));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rdy_hist = '0; idx = 0; cyc = 0;
        gap_left = gaps ? $urandom_range(0, 5) : 0;
        while (idx < n && (busy_a || busy_b) && cyc < 400) begin
            if (gap_left > 0) begin
                step_valid = 1'b0; step_last = 1'b0; gap_left--;
            end else begin
                step_valid = 1'b1; step_data = tr_q[idx]; step_last = (idx == n - 1);
            end
            start = mid_start && (idx == 1);
            rdy_hist = {rdy_hist[14:0], rdy_a};
            acc = step_valid && (!busy_a || rdy_a) && (!busy_b || rdy_b);
            @(negedge clk); cyc++;
            if (acc) begin
                idx++;
                gap_left = gaps ? $urandom_range(0, 5) : 0;
            end
        end
        start = 1'b0;
        if (cyc >= 400) check("drive_timeout", 0, 1);
        w = 0;
        while (1) begin
            rdy_hist = {rdy_hist[14:0], rdy_a};
            if ((done_a && done_b) || w >= 20) break;
            @(negedge clk); w++;
        end
        check("done_a", done_a, 1);
        check("done_b", done_b, 1);
        check("busy_a_end", busy_a, 0);
        // scoreboard
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            check("pass_a", pass_a, ea[74]);
            check("fidx_a", fi_a, ea[73:42]);
            check("fmask_a", fm_a, ea[41:32]);
            check("steps_a", sc_a, ea[31:0]);
            check("dstep_a", dstep_a, tr_q[ea[31:0]]);
            check("pass_b", pass_b, eb[74]);
            check("fidx_b", fi_b, eb[73:42]);
            check("fmask_b", fm_b, eb[41:32]);
            check("steps_b", sc_b, eb[31:0]);
            check("dstep_b", dstep_b, tr_q[eb[31:0]]);
        end
        // A finished check accepts nothing more and keeps its result
        step_valid = 1'b1; step_last = 1'b1; step_data = tr_q[0];
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | rdy_a | rdy_b | busy_a | busy_b;
        end
        check("quiet_after_done", saw, 0);
        check("done_sticky", done_a & done_b, 1);
        step_valid = 1'b0; step_last = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx, cyc;
        bit acc;
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", rdy_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_fidx", fi_a, 0);
        check("rst_fmask", fm_a, 0);
        check("rst_steps", sc_a, 0);
        check("rst_dstep", dstep_a, 0);
        check("rst_state", st_a, IDLE);

        // clean 3-step trace, valid held high
        run_trace(3, 0, 10'h000, 32'd0, 0, 0);
        check("ready_toggle", rdy_hist[5:0], 6'b101010);

        // eax of step 2 off by one
        run_trace(3, 2, 10'h001, 32'd1, 0, 0);

        // eip and eflags wrong on every step: only the 0FF instance passes
        run_trace(4, -1, 10'h300, 32'd5, 0, 0);

        // single-step trace
        run_trace(1, 0, 10'h000, 32'd0, 0, 0);

        // reset while in CHECK with one step already verified
        build_trace(3, 0, 10'h000, 32'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0; cyc = 0;
        while (!(st_a == CHECK && sc_a == 32'd1) && cyc < 50) begin
            step_valid = 1'b1; step_data = tr_q[idx]; step_last = 1'b0;
            acc = rdy_a;
            @(negedge clk); cyc++;
            if (acc) idx++;
        end
        check("reach_check", cyc < 50, 1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", rdy_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_pass", pass_a, 0);
        check("arst_steps", sc_a, 0);
        check("arst_fidx", fi_a, 0);
        check("arst_fmask", fm_a, 0);
        check("arst_dstep", dstep_a, 0);
        check("arst_state", st_a, IDLE);
        step_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_trace(2, 0, 10'h000, 32'd0, 0, 0);

        // mid-trace start pulses plus valid gaps
        run_trace(5, 0, 10'h000, 32'd0, 1, 1);
        run_trace(5, 3, 10'h010, 32'd7, 1, 1);

        // random traces
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 6);
            run_trace(n, $urandom_range(0, n - 1), 10'(1 << $urandom_range(0, 9)),
                      32'($urandom_range(1, 255)), 1, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
